// File: rtl/front_panel_led_sampler_if.sv
// front_panel_led_sampler_if
//   Bus bundle between the CPU/video side and the front-panel LED sampler.
//   master : drives the CPU sample inputs and vga_vs, observes the LEDs.
//   slave  : the sampler itself.
//   Signals:
//     sample_en          qualifies the CPU inputs this cycle
//     cpu_addr/data/status/other  raw indicator sources (16/8/8/4 bits)
//     vga_vs             active-low vertical sync
//     addrLEDs/dataLEDs/statusLEDs/otherLEDs  registered LED state
//     frame_tick         one-cycle pulse on each LED update
interface front_panel_led_sampler_if;
    logic        sample_en;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic [7:0]  cpu_status;
    logic [3:0]  cpu_other;
    logic        vga_vs;
    logic [15:0] addrLEDs;
    logic [7:0]  dataLEDs;
    logic [7:0]  statusLEDs;
    logic [3:0]  otherLEDs;
    logic        frame_tick;

    modport master (
        output sample_en, cpu_addr, cpu_data, cpu_status, cpu_other, vga_vs,
        input  addrLEDs, dataLEDs, statusLEDs, otherLEDs, frame_tick
    );

    modport slave (
        input  sample_en, cpu_addr, cpu_data, cpu_status, cpu_other, vga_vs,
        output addrLEDs, dataLEDs, statusLEDs, otherLEDs, frame_tick
    );
endinterface

// File: rtl/front_panel_led_sampler.sv
// front_panel_led_sampler
//   Averages 36 fast-changing CPU indicator bits over one video frame and
//   shows each as a steady LED. Every qualified sample bumps a frame total and
//   a per-LED high count; on the vga_vs falling edge each LED latches whether
//   it was high for at least half the frame, then the counters restart.
//   Counters saturate at 2^CNT_W-1 and freeze until the next frame edge.
//
//   Build option: define FP_PEAK_HOLD_EN to light an LED if its bit was seen
//   high at least once in the frame (instead of the majority rule).
//
//   Parameters: CNT_W  width of the frame total and of each high counter
//   Ports:
//     clk    single clock (shared with video timing)
//     reset  synchronous, active-high
//     bus    front_panel_led_sampler_if.slave (CPU inputs, vga_vs, LEDs,
//            frame_tick)

// One LED lane: high counter plus the registered LED.
module fp_led_lane #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             load,        // frame_tick with a non-empty frame
    input  logic             sample_en,
    input  logic             sat,         // frame total is saturated
`ifndef FP_PEAK_HOLD_EN
    input  logic [CNT_W-1:0] total,
`endif
    input  logic             bit_in,
    output logic             led
);
    logic [CNT_W-1:0] cnt;
    logic             lit;

    // The frame_tick sample opens the new frame rather than closing the old.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (frame_tick)
            cnt <= CNT_W'(sample_en & bit_in);
        else if (sample_en && !sat && bit_in)
            cnt <= cnt + 1'b1;
    end

`ifdef FP_PEAK_HOLD_EN
    assign lit = (cnt != '0);
`else
    // 2*cnt >= total in CNT_W+1 bits; ties light.
    assign lit = ({cnt, 1'b0} >= {1'b0, total});
`endif

    always_ff @(posedge clk) begin
        if (reset)
            led <= 1'b0;
        else if (load)
            led <= lit;
    end
endmodule

module front_panel_led_sampler #(
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    front_panel_led_sampler_if.slave  bus
);
    localparam int NUM_LANES = 36;

    logic                 vs_d;
    logic                 frame_tick;
    logic [CNT_W-1:0]     total;
    logic                 sat;
    logic                 load;
    logic [NUM_LANES-1:0] led_bits;
    logic [NUM_LANES-1:0] leds;

    assign led_bits = {bus.cpu_other, bus.cpu_status, bus.cpu_data, bus.cpu_addr};

    // vs_d resets high so a sync already low out of reset still gives a tick.
    always_ff @(posedge clk) begin
        if (reset)
            vs_d <= 1'b1;
        else
            vs_d <= bus.vga_vs;
    end

    assign frame_tick     = vs_d & ~bus.vga_vs;
    assign bus.frame_tick = frame_tick;

    assign sat  = &total;
    // An empty frame leaves the LEDs as they were.
    assign load = frame_tick & (|total);

    always_ff @(posedge clk) begin
        if (reset)
            total <= '0;
        else if (frame_tick)
            total <= CNT_W'(bus.sample_en);
        else if (bus.sample_en && !sat)
            total <= total + 1'b1;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        fp_led_lane #(.CNT_W(CNT_W)) u_lane (
            .clk        (clk),
            .reset      (reset),
            .frame_tick (frame_tick),
            .load       (load),
            .sample_en  (bus.sample_en),
            .sat        (sat),
`ifndef FP_PEAK_HOLD_EN
            .total      (total),
`endif
            .bit_in     (led_bits[i]),
            .led        (leds[i])
        );
    end

    assign bus.addrLEDs   = leds[15:0];
    assign bus.dataLEDs   = leds[23:16];
    assign bus.statusLEDs = leds[31:24];
    assign bus.otherLEDs  = leds[35:32];
endmodule

// File: tb/tb_front_panel_led_sampler.sv
// Bench for front_panel_led_sampler: two instances (CNT_W=16 and CNT_W=4)
// share one stimulus stream. A frame-level model keeps plain integer counts;
// expected LED words are queued on each modelled frame edge and a monitor
// pops them whenever a DUT signals frame_tick.
module tb_front_panel_led_sampler;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    front_panel_led_sampler_if a_if ();
    front_panel_led_sampler_if b_if ();

    front_panel_led_sampler #(.CNT_W(16)) u_dut16 (.clk(clk), .reset(reset), .bus(a_if));
    front_panel_led_sampler #(.CNT_W(4))  u_dut4  (.clk(clk), .reset(reset), .bus(b_if));

    int total = 0;
    int bad   = 0;

    // model state, index 0 = CNT_W 16, 1 = CNT_W 4
    int          hc [2][36];
    int          tot[2];
    int          mx [2] = '{65535, 15};
    logic [35:0] mled[2];
    logic        mvs_d;
    logic [35:0] q0[$];
    logic [35:0] q1[$];

    function automatic logic [35:0] leds_of(input int d);
        if (d == 0)
            return {a_if.otherLEDs, a_if.statusLEDs, a_if.dataLEDs, a_if.addrLEDs};
        return {b_if.otherLEDs, b_if.statusLEDs, b_if.dataLEDs, b_if.addrLEDs};
    endfunction

    function automatic logic [35:0] mkv(input logic [15:0] a, input logic [7:0] dt,
                                        input logic [7:0] st, input logic [3:0] ot);
        return {ot, st, dt, a};
    endfunction

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock of stimulus plus the model's view of the coming edge.
    task automatic cyc(input logic rst, input logic se, input logic vs, input logic [35:0] v);
        logic ft;
        logic [35:0] nl;
        @(negedge clk);
        reset = rst;
        a_if.sample_en = se; b_if.sample_en = se;
        a_if.vga_vs = vs;    b_if.vga_vs = vs;
        {a_if.cpu_other, a_if.cpu_status, a_if.cpu_data, a_if.cpu_addr} = v;
        {b_if.cpu_other, b_if.cpu_status, b_if.cpu_data, b_if.cpu_addr} = v;
        #1;
        ft = mvs_d & ~vs;
        chk("frame_tick16", {35'b0, a_if.frame_tick}, {35'b0, ft});
        chk("frame_tick4",  {35'b0, b_if.frame_tick}, {35'b0, ft});
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                tot[d] = 0;
                for (int i = 0; i < 36; i++) hc[d][i] = 0;
                mled[d] = '0;
                if (ft) begin
                    if (d == 0) q0.push_back('0); else q1.push_back('0);
                end
            end else if (ft) begin
                if (tot[d] > 0) begin
                    for (int i = 0; i < 36; i++) begin
`ifdef FP_PEAK_HOLD_EN
                        nl[i] = (hc[d][i] != 0);
`else
                        nl[i] = (2 * hc[d][i] >= tot[d]);
`endif
                    end
                    mled[d] = nl;
                end
                if (d == 0) q0.push_back(mled[d]); else q1.push_back(mled[d]);
                tot[d] = se ? 1 : 0;
                for (int i = 0; i < 36; i++) hc[d][i] = (se && v[i]) ? 1 : 0;
            end else if (se && tot[d] < mx[d]) begin
                tot[d]++;
                for (int i = 0; i < 36; i++) hc[d][i] += v[i] ? 1 : 0;
            end
        end
        mvs_d = rst ? 1'b1 : vs;
    endtask

    task automatic frame(input int n, input logic se, input logic [35:0] v);
        for (int k = 0; k < n; k++) cyc(1'b0, se, 1'b1, v);
    endtask

    // Monitor: LEDs seen the cycle after a DUT frame_tick go to the scoreboard.
    initial begin
        logic p0, p1;
        p0 = 1'b0; p1 = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (p0) begin
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb16: got tick with leds %h expected no tick", leds_of(0));
                end else chk("sb16", leds_of(0), q0.pop_front());
            end
            if (p1) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb4: got tick with leds %h expected no tick", leds_of(1));
                end else chk("sb4", leds_of(1), q1.pop_front());
            end
            p0 = (a_if.frame_tick === 1'b1);
            p1 = (b_if.frame_tick === 1'b1);
        end
    end

    initial begin
        logic [63:0] r;
        logic [35:0] base, v;
        logic [7:0]  exp_d;
        int n;
        reset = 1'b1;
        a_if.sample_en = 0; b_if.sample_en = 0;
        a_if.vga_vs = 1;    b_if.vga_vs = 1;
        {a_if.cpu_other, a_if.cpu_status, a_if.cpu_data, a_if.cpu_addr} = '0;
        {b_if.cpu_other, b_if.cpu_status, b_if.cpu_data, b_if.cpu_addr} = '0;
        mvs_d = 1'b1;
        for (int d = 0; d < 2; d++) begin
            tot[d] = 0; mled[d] = '0;
            for (int i = 0; i < 36; i++) hc[d][i] = 0;
        end

        // reset state
        cyc(1, 0, 1, '0);
        cyc(1, 0, 1, '0);
        cyc(0, 0, 1, '0);
        chk("reset16", leds_of(0), '0);
        chk("reset4",  leds_of(1), '0);

        // steady address pattern for 1000 samples
        frame(1000, 1, mkv(16'hA5A5, 0, 0, 0));
        cyc(0, 0, 0, '0);
        chk("addr_before", {20'b0, a_if.addrLEDs}, 36'h0);
        cyc(0, 0, 0, '0);
        chk("addr16", {20'b0, a_if.addrLEDs}, {20'b0, 16'hA5A5});
        chk("addr4",  {20'b0, b_if.addrLEDs}, {20'b0, 16'hA5A5});

        // 3 high of 8 -> dark (peak: lit); 4 of 8 -> lit
        frame(3, 1, mkv(0, 8'hFF, 0, 0));
        frame(5, 1, mkv(0, 8'h00, 0, 0));
        cyc(0, 0, 0, '0);
        cyc(0, 0, 0, '0);
`ifdef FP_PEAK_HOLD_EN
        exp_d = 8'hFF;
`else
        exp_d = 8'h00;
`endif
        chk("data_3of8", {28'b0, a_if.dataLEDs}, {28'b0, exp_d});
        frame(4, 1, mkv(0, 8'hFF, 0, 0));
        frame(4, 1, mkv(0, 8'h00, 0, 0));
        cyc(0, 0, 0, '0);
        cyc(0, 0, 0, '0);
        chk("data_4of8", {28'b0, a_if.dataLEDs}, {28'b0, 8'hFF});
        frame(1, 1, mkv(0, 8'hFF, 0, 0));
        frame(7, 1, mkv(0, 8'h00, 0, 0));
        cyc(0, 0, 0, '0);
        cyc(0, 0, 0, '0);
        chk("data_1of8", {28'b0, a_if.dataLEDs}, {28'b0, exp_d});

        // empty frame: LEDs hold
        frame(20, 0, mkv(16'hFFFF, 8'hFF, 8'hFF, 4'hF));
        cyc(0, 0, 0, '0);
        cyc(0, 0, 0, '0);
        chk("empty_hold", {28'b0, a_if.dataLEDs}, {28'b0, exp_d});

        // saturation: 15 high then 5 low -> lit on both widths
        frame(15, 1, mkv(0, 0, 8'h01, 0));
        frame(5,  1, mkv(0, 0, 8'h00, 0));
        cyc(0, 0, 0, '0);
        cyc(0, 0, 0, '0);
        chk("sat_st16", {28'b0, a_if.statusLEDs}, {28'b0, 8'h01});
        chk("sat_st4",  {28'b0, b_if.statusLEDs}, {28'b0, 8'h01});
        // 15 low then 20 high: narrow counter freezes on the lows
        frame(15, 1, mkv(0, 0, 8'h00, 0));
        frame(20, 1, mkv(0, 0, 8'h02, 0));
        cyc(0, 0, 0, '0);
        cyc(0, 0, 0, '0);
        chk("sat2_st16", {28'b0, a_if.statusLEDs}, {28'b0, 8'h02});
        chk("sat2_st4",  {28'b0, b_if.statusLEDs}, {28'b0, 8'h00});

        // sample in the tick cycle opens the next frame
        frame(3, 0, '0);
        cyc(0, 1, 0, mkv(0, 0, 0, 4'hF));
        frame(1, 1, mkv(0, 0, 0, 4'h0));
        cyc(0, 0, 0, '0);
        cyc(0, 0, 0, '0);
        chk("other_tie", {32'b0, a_if.otherLEDs}, {32'b0, 4'hF});

        // reset on the sync edge after a full frame discards everything
        frame(30, 1, mkv(16'hFFFF, 8'hFF, 8'hFF, 4'hF));
        cyc(1, 1, 0, mkv(16'hFFFF, 8'hFF, 8'hFF, 4'hF));
        cyc(0, 0, 1, '0);
        chk("rst_edge16", leds_of(0), '0);
        chk("rst_edge4",  leds_of(1), '0);
        frame(5, 0, '0);
        cyc(0, 0, 0, '0);
        cyc(0, 0, 0, '0);
        chk("rst_cnt16", leds_of(0), '0);

        // randomized frames, occasional mid-frame reset
        for (int f = 0; f < 40; f++) begin
            r = {$urandom(), $urandom()};
            base = r[35:0];
            n = $urandom_range(2, 40);
            for (int k = 0; k < n; k++) begin
                r = {$urandom(), $urandom()};
                v = base ^ (r[35:0] & {$urandom(), $urandom()} & {$urandom(), $urandom()});
                cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), 1'b1, v);
            end
            r = {$urandom(), $urandom()};
            cyc(0, $urandom_range(0, 1) == 1, 0, r[35:0]);
            if ($urandom_range(0, 1) == 1) cyc(0, 1, 0, base);
        end
        frame(3, 0, '0);
        @(negedge clk);
        #3;
        if (q0.size() != 0 || q1.size() != 0) begin
            total++; bad++;
            $display("FAIL sb_drain: got %0d/%0d pending expected 0", q0.size(), q1.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
